// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline control block.
package pipe_ctrl_pkg;

   // Memory-handshake FSM states.
   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StError   = 2'd2
   } state_e;

   localparam int unsigned CntWDefault       = 16;
   localparam int unsigned MemTimeoutDefault = 63;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear first, otherwise increment until all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: memory-access FSM, freeze/flush/bubble arbitration and
// performance counters for stalled cycles and branch flushes.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = CntWDefault,
   parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             hazard_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   input  logic             cnt_clr_i,
   output logic             mem_start_o,
   output logic             freeze_all_o,
   output logic             freeze_front_o,
   output logic             flush_if_id_o,
   output logic             bubble_exe_o,
   output logic             mem_error_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   // wait_cnt must be able to hold MEM_TIMEOUT itself.
   localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

   logic mem_start;
   logic freeze_all;
   logic mem_error;
   logic freeze_front;
   logic flush_if_id;
   logic bubble_exe;

   // FSM next state and memory-side outputs; reset forces outputs low.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_start  = 1'b0;
      freeze_all = 1'b0;
      mem_error  = 1'b0;
      unique case (state_q)
         StRun: begin
            // mem_ready is ignored here so an access always takes >= 1 wait cycle.
            if (mem_req_i) begin
               mem_start  = 1'b1;
               freeze_all = 1'b1;
               state_d    = StMemWait;
               wait_cnt_d = '0;
            end
         end
         StMemWait: begin
            if (mem_ready_i) begin
               state_d = StRun;
            end else begin
               freeze_all = 1'b1;
               if (wait_cnt_q == WaitW'(MEM_TIMEOUT)) begin
                  state_d = StError;
               end else begin
                  wait_cnt_d = wait_cnt_q + WaitW'(1);
               end
            end
         end
         StError: begin
            freeze_all = 1'b1;
            mem_error  = 1'b1;
         end
         default: begin
            state_d = StRun;
         end
      endcase
      if (rst_i) begin
         mem_start  = 1'b0;
         freeze_all = 1'b0;
         mem_error  = 1'b0;
      end
   end

   // Front-end arbitration: freeze beats branch, branch beats hazard.
   always_comb begin
      freeze_front = 1'b0;
      flush_if_id  = 1'b0;
      bubble_exe   = 1'b0;
      if (!rst_i && !freeze_all) begin
         if (branch_taken_i) begin
            flush_if_id = 1'b1;
            bubble_exe  = 1'b1;
         end else if (hazard_i) begin
            freeze_front = 1'b1;
            bubble_exe   = 1'b1;
         end
      end
   end

   // FSM state and wait counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (cnt_clr_i),
      .inc_i (freeze_all | freeze_front),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (cnt_clr_i),
      .inc_i (flush_if_id),
      .cnt_o (flush_cnt_o)
   );

   assign mem_start_o    = mem_start;
   assign freeze_all_o   = freeze_all;
   assign freeze_front_o = freeze_front;
   assign flush_if_id_o  = flush_if_id;
   assign bubble_exe_o   = bubble_exe;
   assign mem_error_o    = mem_error;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver issues per-cycle stimulus and
// pushes the behaviourally predicted outputs; a monitor pops and compares.
module tb_pipeline_ctrl;

   localparam int unsigned CW = 4;
   localparam int unsigned TO = 4;
   localparam int CntMax = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic hazard = 1'b0, branch = 1'b0, req = 1'b0, rdy = 1'b0, clr = 1'b0;

   logic          ms, fa, ff, fl, bub, err;
   logic [CW-1:0] sc, fc;

   pipeline_ctrl #(
      .CNT_W       (CW),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .hazard_i       (hazard),
      .branch_taken_i (branch),
      .mem_req_i      (req),
      .mem_ready_i    (rdy),
      .cnt_clr_i      (clr),
      .mem_start_o    (ms),
      .freeze_all_o   (fa),
      .freeze_front_o (ff),
      .flush_if_id_o  (fl),
      .bubble_exe_o   (bub),
      .mem_error_o    (err),
      .stall_cnt_o    (sc),
      .flush_cnt_o    (fc)
   );

   typedef struct packed {
      logic          ms, fa, ff, fl, bub, err;
      logic [CW-1:0] sc, fc;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Behavioural model: an access is either outstanding or not, the unit is
   // either dead (timed out) or alive, and counters are plain integers.
   bit busy   = 0;
   bit dead   = 0;
   int waited = 0;
   int stall_m = 0;
   int flush_m = 0;

   task automatic step(input logic r, h, b, mq, md, c);
      obs_t e;
      int   stalled;
      @(posedge clk);
      #1;
      rst = r; hazard = h; branch = b; req = mq; rdy = md; clr = c;
      e = '0;
      e.sc = CW'(stall_m);
      e.fc = CW'(flush_m);
      if (!r) begin
         e.fa  = dead || (busy ? !md : mq);
         e.ms  = !dead && !busy && mq;
         e.err = dead;
         e.fl  = !e.fa && b;
         e.bub = !e.fa && (b || h);
         e.ff  = !e.fa && !b && h;
      end
      exp_q.push_back(e);
      if (r) begin
         busy = 0; dead = 0; waited = 0; stall_m = 0; flush_m = 0;
      end else begin
         stalled = (e.fa || e.ff) ? 1 : 0;
         if (c) begin
            stall_m = 0;
            flush_m = 0;
         end else begin
            stall_m = (stall_m + stalled > CntMax) ? CntMax : stall_m + stalled;
            flush_m = (flush_m + int'(e.fl) > CntMax) ? CntMax : flush_m + int'(e.fl);
         end
         if (dead) begin
            // only reset leaves the error condition
         end else if (busy) begin
            if (md) busy = 0;
            else if (waited == TO) begin
               dead = 1;
               busy = 0;
            end else waited++;
         end else if (mq) begin
            busy   = 1;
            waited = 0;
         end
      end
   endtask

   // Monitor: every cycle the DUT presents a full output vector.
   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{ms: ms, fa: fa, ff: ff, fl: fl, bub: bub, err: err, sc: sc, fc: fc};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs cycle %0d: got ms=%b fa=%b ff=%b fl=%b bub=%b err=%b sc=%0d fc=%0d, expected ms=%b fa=%b ff=%b fl=%b bub=%b err=%b sc=%0d fc=%0d",
                        cyc, a.ms, a.fa, a.ff, a.fl, a.bub, a.err, a.sc, a.fc,
                        e.ms, e.fa, e.ff, e.fl, e.bub, e.err, e.sc, e.fc);
            end
            cyc++;
         end
      end
   end

   initial begin
      // reset state
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // memory stall, ready after three wait cycles, single start pulse
      step(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);

      // branch beats hazard
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // freeze beats branch
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // timeout into error, ready ignored there, only reset exits
      step(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, i[0], 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 0);
      step(1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // saturation, then clear together with a stall
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      // back-to-back accesses, then reset mid-wait with a request pending
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(99) < 2)  ? 1'b1 : 1'b0,
              ($urandom_range(99) < 30) ? 1'b1 : 1'b0,
              ($urandom_range(99) < 20) ? 1'b1 : 1'b0,
              ($urandom_range(99) < 30) ? 1'b1 : 1'b0,
              ($urandom_range(99) < 25) ? 1'b1 : 1'b0,
              ($urandom_range(99) < 3)  ? 1'b1 : 1'b0);
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
